// File: rtl/layer_arb_if.sv
// -----------------------------------------------------------------------------
// layer_arb_if
// Bundles the pixel/layer, sync and configuration signals of the layer
// arbiter so that the compositor and its source share one connection.
//
// Signals
//   en_i          display-active flag, aligned with the layer inputs
//   v_sync_i      vertical sync, active-low
//   layer_rgb_i   NL packed layer colours, layer k at [k*RGB_W +: RGB_W]
//   layer_alpha_i per-layer opacity, 1 = opaque pixel present
//   bg_rgb_i      background colour
//   cfg_en_i      requested layer-enable mask
//   cfg_wr_i      single-cycle strobe capturing cfg_en_i
//   rgb_o         composited pixel
//   frame_o       one-cycle pulse per frame boundary while running
//   frame_cnt_o   frames completed since reset (wraps)
//   hit_o         per-layer collision with layer 0 in the previous frame
//
// Modports
//   master  pixel source / controller side (drives *_i, reads *_o)
//   slave   arbiter side (reads *_i, drives *_o)
// -----------------------------------------------------------------------------
interface layer_arb_if #(
    parameter int RGB_W = 12,
    parameter int NL    = 4
);
    logic                  en_i;
    logic                  v_sync_i;
    logic [NL*RGB_W-1:0]   layer_rgb_i;
    logic [NL-1:0]         layer_alpha_i;
    logic [RGB_W-1:0]      bg_rgb_i;
    logic [NL-1:0]         cfg_en_i;
    logic                  cfg_wr_i;
    logic [RGB_W-1:0]      rgb_o;
    logic                  frame_o;
    logic [7:0]            frame_cnt_o;
    logic [NL-2:0]         hit_o;

    modport master (
        output en_i, v_sync_i, layer_rgb_i, layer_alpha_i, bg_rgb_i,
               cfg_en_i, cfg_wr_i,
        input  rgb_o, frame_o, frame_cnt_o, hit_o
    );

    modport slave (
        input  en_i, v_sync_i, layer_rgb_i, layer_alpha_i, bg_rgb_i,
               cfg_en_i, cfg_wr_i,
        output rgb_o, frame_o, frame_cnt_o, hit_o
    );
endinterface

// File: rtl/layer_arb.sv
// -----------------------------------------------------------------------------
// layer_arb
// Sprite layer compositor. Picks, per pixel, the lowest-index layer that is
// both opaque and enabled (layer 0 = player has highest priority), falling
// back to the background colour, and blanks outside the active display.
// Layer enables are double-buffered so that a new mask only takes effect at
// a frame boundary. Collisions between the player layer and each other
// layer are accumulated over a frame and published at the boundary.
//
// Ports
//   clk_vga  pixel clock, all state on the rising edge
//   rst      asynchronous active-low reset
//   bus      layer_arb_if.slave (see interface header for signal list)
//
// Timing
//   Two-cycle pipeline: stage 1 registers the pixel inputs, stage 2
//   registers the composited colour. Frame boundary is the cycle in which
//   the live v_sync_i is low while its registered copy is still high.
//   Until the first boundary after reset the block sits in SYNC with a
//   blank output, so a reset released mid-frame never shows a torn frame.
// -----------------------------------------------------------------------------
module layer_arb #(
    parameter int RGB_W = 12,
    parameter int NL    = 4
) (
    input  logic       clk_vga,
    input  logic       rst,
    layer_arb_if.slave bus
);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [NL-1:0] MASK_RST = {{(NL-1){1'b0}}, 1'b1};

    // State
    logic [0:0]           state_r;
    logic [0:0]           state_nx_s;
    logic                 vs_r;
    logic [NL-1:0]        pending_r;
    logic [NL-1:0]        active_r;

    // Stage 1 pipeline registers
    logic                 s1_en_r;
    logic [NL*RGB_W-1:0]  s1_rgb_r;
    logic [NL-1:0]        s1_alpha_r;
    logic [RGB_W-1:0]     s1_bg_r;

    // Outputs and accumulators
    logic [RGB_W-1:0]     rgb_r;
    logic                 frame_r;
    logic [7:0]           frame_cnt_r;
    logic [NL-2:0]        hit_r;
    logic [NL-2:0]        hit_acc_r;

    // Combinational helpers
    logic                 boundary_s;
    logic                 run_s;
    logic                 frame_evt_s;
    logic [NL-1:0]        vis_s;
    logic [RGB_W-1:0]     layer_s;
    logic [RGB_W-1:0]     comp_s;
    logic [NL-2:0]        hit_now_s;

    // Frame boundary: live sync already low, registered copy still high.
    always_comb begin
        boundary_s  = vs_r & ~bus.v_sync_i;
        run_s       = (state_r == ST_RUN);
        frame_evt_s = boundary_s & run_s;
    end

    // Next-state logic: SYNC waits for a boundary, RUN is left only by reset.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_SYNC: begin
                if (boundary_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_SYNC;
                end
            end
            ST_RUN:  state_nx_s = ST_RUN;
            default: state_nx_s = ST_SYNC;
        endcase
    end

    // Visible layers: opaque in the stage-1 pixel and enabled in the live mask.
    always_comb begin
        vis_s = s1_alpha_r & active_r;
    end

    // Priority select; scanning downward lets the lowest visible index win.
    always_comb begin
        layer_s = s1_bg_r;
        for (int k = NL - 1; k >= 0; k--) begin
            if (vis_s[k]) begin
                layer_s = s1_rgb_r[k*RGB_W +: RGB_W];
            end else begin
                layer_s = layer_s;
            end
        end
        if (s1_en_r) begin
            comp_s = layer_s;
        end else begin
            comp_s = {RGB_W{1'b0}};
        end
    end

    // Collision of each non-player layer with the player in the stage-1 pixel.
    always_comb begin
        hit_now_s = {(NL-1){1'b0}};
        for (int k = 1; k < NL; k++) begin
            hit_now_s[k-1] = s1_en_r & vis_s[0] & vis_s[k];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered copy of v_sync_i used for falling-edge detection.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            vs_r <= 1'b1;
        end else begin
            vs_r <= bus.v_sync_i;
        end
    end

    // Pending mask follows every write; a write on a boundary edge is not
    // seen by the active mask until the following boundary.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            pending_r <= MASK_RST;
        end else if (bus.cfg_wr_i) begin
            pending_r <= bus.cfg_en_i;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Active mask is swapped in on every boundary, including SYNC->RUN.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            active_r <= MASK_RST;
        end else if (boundary_s) begin
            active_r <= pending_r;
        end else begin
            active_r <= active_r;
        end
    end

    // Stage 1: capture the pixel inputs.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            s1_en_r    <= 1'b0;
            s1_rgb_r   <= {(NL*RGB_W){1'b0}};
            s1_alpha_r <= {NL{1'b0}};
            s1_bg_r    <= {RGB_W{1'b0}};
        end else begin
            s1_en_r    <= bus.en_i;
            s1_rgb_r   <= bus.layer_rgb_i;
            s1_alpha_r <= bus.layer_alpha_i;
            s1_bg_r    <= bus.bg_rgb_i;
        end
    end

    // Stage 2: composited colour, blanked while still in SYNC.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            rgb_r <= {RGB_W{1'b0}};
        end else if (run_s) begin
            rgb_r <= comp_s;
        end else begin
            rgb_r <= {RGB_W{1'b0}};
        end
    end

    // Frame pulse and frame counter; the SYNC->RUN boundary is not counted.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            frame_r     <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else if (frame_evt_s) begin
            frame_r     <= 1'b1;
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_r     <= 1'b0;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Sticky hit accumulator; the boundary cycle's own hit goes straight
    // into the published value so nothing is lost across the clear.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            hit_acc_r <= {(NL-1){1'b0}};
            hit_r     <= {(NL-1){1'b0}};
        end else if (frame_evt_s) begin
            hit_acc_r <= {(NL-1){1'b0}};
            hit_r     <= hit_acc_r | hit_now_s;
        end else if (run_s) begin
            hit_acc_r <= hit_acc_r | hit_now_s;
            hit_r     <= hit_r;
        end else begin
            hit_acc_r <= hit_acc_r;
            hit_r     <= hit_r;
        end
    end

    assign bus.rgb_o       = rgb_r;
    assign bus.frame_o     = frame_r;
    assign bus.frame_cnt_o = frame_cnt_r;
    assign bus.hit_o       = hit_r;

endmodule

// File: doc/layer_arb.md
LAYER_ARB -- requirements
Module: layer_arb

Interface
REQ-001 SHALL have parameter RGB_W, default 12, meaning the packed RGB pixel width and equal to COLOR_RGB_DEPTH.
REQ-002 SHALL have parameter NL, fixed at 4, meaning the number of sprite layers; index 0 is the player layer.
REQ-003 clk_vga  input  1  pixel clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  display-active flag from the display controller, aligned with layer inputs.
REQ-006 v_sync_i  input  1  vertical sync, active-low; frame boundary = cycle where registered v_sync_i goes 1->0.
REQ-007 layer_rgb_i  input  NL*RGB_W  per-layer pixel colour; layer k occupies bits [k*RGB_W +: RGB_W].
REQ-008 layer_alpha_i  input  NL  per-layer opacity; 1 = opaque pixel present.
REQ-009 bg_rgb_i  input  RGB_W  background colour.
REQ-010 cfg_en_i  input  NL  requested layer-enable mask.
REQ-011 cfg_wr_i  input  1  single-cycle strobe capturing cfg_en_i.
REQ-012 rgb_o  output  RGB_W  composited pixel.
REQ-013 frame_o  output  1  one-cycle pulse on each frame boundary, from RUN only.
REQ-014 frame_cnt_o  output  8  frames completed since reset.
REQ-015 hit_o  output  NL-1  per-layer collision with layer 0 during the previous frame.

Function
REQ-016 SHALL implement FSM states SYNC and RUN; reset enters SYNC; SYNC->RUN on the first frame boundary; RUN has no exit except reset.
REQ-017 In SYNC, rgb_o SHALL be 0, frame_o 0, and no hit accumulation SHALL occur.
REQ-018 SHALL hold a pending mask, reset 4'b0001, loaded from cfg_en_i when cfg_wr_i=1, and an active mask, reset 4'b0001, loaded from pending on each frame boundary.
REQ-019 SHALL take the pending value from before the same edge when cfg_wr_i and a frame boundary coincide; the new write stays pending until the next boundary.
REQ-020 Pipeline SHALL be 2 cycles: stage 1 registers en_i, layer_rgb_i, layer_alpha_i and bg_rgb_i; stage 2 registers rgb_o.
REQ-021 Stage 2 SHALL select the lowest index k with alpha[k]=1 and active[k]=1; if none, bg_rgb_i from stage 1; if stage-1 en=0, 0.
REQ-022 A hit on layer k (1..3) SHALL set when stage-1 en=1, alpha[0]&active[0]=1 and alpha[k]&active[k]=1; hit bits are sticky within a frame.
REQ-023 On a frame boundary in RUN, hit_o SHALL load the accumulated hits, including any hit in that same cycle, and the accumulator SHALL clear.
REQ-024 frame_cnt_o SHALL increment on each frame_o pulse and wrap from 255 to 0.
REQ-025 frame_o SHALL assert in the cycle after the boundary edge is detected, and only in RUN (not on the SYNC->RUN boundary).
REQ-026 Boundary detection SHALL use a 1-cycle registered copy of v_sync_i, reset to 1.

Reset
REQ-027 While rst=0: state=SYNC, rgb_o=0, frame_o=0, frame_cnt_o=0, hit_o=0, hit accumulator=0, pending=active=4'b0001, pipeline registers=0.
REQ-028 Deasserting rst mid-frame SHALL leave the block in SYNC until the next v_sync_i falling edge, regardless of en_i.

Verification
REQ-029 Reset, then en_i=1 with layer 0 opaque before any v_sync_i fall -> rgb_o stays 0; after the first fall, rgb_o = layer 0 colour 2 cycles after input.
REQ-030 RUN, active=4'b1111, alpha=4'b0110, rgb1=12'hF00, rgb2=12'h0F0 -> rgb_o=12'hF00 exactly 2 cycles later; with alpha=0 it gives bg_rgb_i; with en_i=0 it gives 0.
REQ-031 cfg_wr_i with cfg_en_i=4'b0011 mid-frame -> selection unchanged until the next boundary, then layers 2 and 3 are ignored; a write coincident with the boundary takes effect one frame later.
REQ-032 alpha[0]=1 and alpha[2]=1 for one en_i cycle -> hit_o=3'b010 after the next boundary; hit_o=3'b000 after the following clean frame.
REQ-033 257 frame boundaries in RUN -> frame_cnt_o=1 after wrap, and exactly one single-cycle frame_o pulse per boundary.
REQ-034 Assert rst mid-frame with hits pending -> all outputs return to reset values immediately (asynchronous), and hit_o=0 after release.
